// File: rtl/cal_engine.sv
// Per-channel PTAT calibration: saturating offset add followed by a W-cycle
// shift-add gain multiply, with valid/ready handshakes on input and output.
module cal_engine #(
    parameter int W   = 12,
    parameter int NCH = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [CW-1:0] in_ch,
    input  logic [W-1:0]  in_data,
    input  logic          coef_we,
    input  logic          coef_sel,
    input  logic [CW-1:0] coef_ch,
    input  logic [W-1:0]  coef_wdata,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [CW-1:0] out_ch,
    output logic [W-1:0]  out_data,
    output logic          out_sat,
    output logic          busy
);

    localparam int CNTW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] UNITY = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ADD, MUL, OUT} state_t;
    state_t state_reg, state_next;

    // Coefficients must reset to defaults, so they live in flops, not RAM.
    logic [W-1:0] offset_mem [NCH];
    logic [W-1:0] gain_mem   [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_coef
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    offset_mem[gi] <= '0;
                    gain_mem[gi]   <= UNITY;
                end else if (coef_we && coef_ch == CW'(gi)) begin
                    if (coef_sel) gain_mem[gi]   <= coef_wdata;
                    else          offset_mem[gi] <= coef_wdata;
                end
            end
        end
    endgenerate

    logic [CW-1:0]   ch_reg;
    logic [W-1:0]    data_reg;
    logic            sat_reg;
    logic [2*W-1:0]  mcand_reg;
    logic [W-1:0]    mplier_reg;
    logic [2*W-1:0]  prod_reg;
    logic [CNTW-1:0] cnt_reg;
    logic [W-1:0]    out_data_reg;
    logic [CW-1:0]   out_ch_reg;
    logic            out_sat_reg;

    logic [W-1:0]   offset_sel, gain_sel;
    logic [W+1:0]   sum_next;
    logic [W-1:0]   sum_sat_next;
    logic           add_sat_next;
    logic [2*W-1:0] prod_next;
    logic [W-1:0]   mul_result_next;
    logic           last_iter;

    // Channels with no coefficient slot fall through as offset 0 / unity gain.
    always_comb begin
        offset_sel = '0;
        gain_sel   = UNITY;
        for (int i = 0; i < NCH; i++) begin
            if (ch_reg == CW'(i)) begin
                offset_sel = offset_mem[i];
                gain_sel   = gain_mem[i];
            end
        end
    end

    always_comb begin
        sum_next     = {2'b00, data_reg} + {{2{offset_sel[W-1]}}, offset_sel};
        sum_sat_next = sum_next[W-1:0];
        add_sat_next = 1'b0;
        if (sum_next[W+1]) begin
            sum_sat_next = '0;
            add_sat_next = 1'b1;
        end else if (sum_next[W]) begin
            sum_sat_next = '1;
            add_sat_next = 1'b1;
        end
        prod_next       = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
        mul_result_next = prod_next[2*W-1] ? '1 : prod_next[2*W-2:W-1];
        last_iter       = (cnt_reg == CNTW'(W-1));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_vld) state_next = ADD;
            ADD:     state_next = MUL;
            MUL:     if (last_iter) state_next = OUT;
            OUT:     if (out_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ch_reg       <= '0;
            data_reg     <= '0;
            sat_reg      <= 1'b0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            prod_reg     <= '0;
            cnt_reg      <= '0;
            out_data_reg <= '0;
            out_ch_reg   <= '0;
            out_sat_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (in_vld) begin
                    ch_reg   <= in_ch;
                    data_reg <= in_data;
                end
                ADD: begin
                    mcand_reg  <= {{W{1'b0}}, sum_sat_next};
                    mplier_reg <= gain_sel;
                    prod_reg   <= '0;
                    cnt_reg    <= '0;
                    sat_reg    <= add_sat_next;
                end
                MUL: begin
                    prod_reg   <= prod_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        out_data_reg <= mul_result_next;
                        out_sat_reg  <= sat_reg | prod_next[2*W-1];
                        out_ch_reg   <= ch_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_rdy   = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign out_vld  = (state_reg == OUT);
    assign out_data = out_data_reg;
    assign out_ch   = out_ch_reg;
    assign out_sat  = out_sat_reg;

endmodule

// File: tb/tb_cal_engine.sv
// Directed bench for cal_engine (W=12, NCH=4): defaults, saturation, gain,
// backpressure, coefficient write race and mid-operation reset.
module tb_cal_engine;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [1:0]  in_ch = '0;
    logic [11:0] in_data = '0;
    logic        coef_we = 1'b0;
    logic        coef_sel = 1'b0;
    logic [1:0]  coef_ch = '0;
    logic [11:0] coef_wdata = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [1:0]  out_ch;
    logic [11:0] out_data;
    logic        out_sat;
    logic        busy;

    int checks = 0;
    int failures = 0;

    cal_engine #(.W(12), .NCH(4)) dut (
        .clk(clk), .nRST(nRST),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_ch(in_ch), .in_data(in_data),
        .coef_we(coef_we), .coef_sel(coef_sel), .coef_ch(coef_ch), .coef_wdata(coef_wdata),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_ch(out_ch), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic write_coef(input logic sel, input logic [1:0] ch, input logic [11:0] val);
        @(negedge clk);
        coef_we = 1'b1; coef_sel = sel; coef_ch = ch; coef_wdata = val;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // Accept one sample, wait for the result, check it, then release it.
    // With race set, gain[0]=0x400 is written on the ADD edge.
    task automatic run_sample(input string tag, input logic [1:0] ch, input logic [11:0] data,
                              input logic [11:0] exp_d, input logic exp_s, input bit race);
        int n;
        @(negedge clk);
        check({tag, " in_rdy"}, in_rdy, 1);
        in_vld = 1'b1; in_ch = ch; in_data = data;
        @(posedge clk); #1;
        in_vld = 1'b0;
        if (race) begin
            coef_we = 1'b1; coef_sel = 1'b1; coef_ch = 2'd0; coef_wdata = 12'h400;
        end
        n = 0;
        do begin
            @(posedge clk); n++; #1;
            if (race && n == 1) coef_we = 1'b0;
        end while (!out_vld && n < 40);
        check({tag, " latency"}, n, 13);
        check({tag, " data"}, out_data, exp_d);
        check({tag, " sat"}, out_sat, exp_s);
        check({tag, " ch"}, out_ch, ch);
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        check({tag, " idle"}, {out_vld, in_rdy, busy}, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst out_vld", out_vld, 0);
        check("rst out_data", out_data, 0);
        check("rst out_ch", out_ch, 0);
        check("rst out_sat", out_sat, 0);
        check("rst busy", busy, 0);
        check("rst in_rdy", in_rdy, 1);
        @(negedge clk);
        nRST = 1'b1;

        run_sample("t1 default", 2'd0, 12'h123, 12'h123, 1'b0, 1'b0);

        write_coef(1'b0, 2'd1, 12'h100);
        run_sample("t2 add_hi", 2'd1, 12'hF80, 12'hFFF, 1'b1, 1'b0);
        run_sample("t2 add_ok", 2'd1, 12'h100, 12'h200, 1'b0, 1'b0);
        write_coef(1'b0, 2'd2, 12'hF00);
        run_sample("t2 add_lo", 2'd2, 12'h050, 12'h000, 1'b1, 1'b0);

        write_coef(1'b1, 2'd3, 12'hC00);
        run_sample("t3 gain", 2'd3, 12'h400, 12'h600, 1'b0, 1'b0);
        write_coef(1'b1, 2'd3, 12'hFFF);
        run_sample("t3 mul_sat", 2'd3, 12'hFFF, 12'hFFF, 1'b1, 1'b0);

        // Backpressure with a concurrent, dropped input
        begin
            int n;
            @(negedge clk);
            in_vld = 1'b1; in_ch = 2'd1; in_data = 12'h100;
            @(posedge clk); #1;
            in_vld = 1'b0;
            n = 0;
            while (!out_vld && n < 40) begin @(posedge clk); n++; #1; end
            check("t4 latency", n, 13);
            in_vld = 1'b1; in_ch = 2'd0; in_data = 12'h555;
            repeat (5) begin
                @(posedge clk); #1;
                check("t4 hold", {out_vld, in_rdy, out_ch, out_data}, {1'b1, 1'b0, 2'd1, 12'h200});
            end
            out_rdy = 1'b1;
            @(posedge clk); #1;
            out_rdy = 1'b0; in_vld = 1'b0;
            check("t4 to_idle", {out_vld, in_rdy, busy}, 3'b010);
            @(posedge clk); #1;
            check("t4 dropped", {out_vld, in_rdy, busy}, 3'b010);
        end

        run_sample("t5 race", 2'd0, 12'h200, 12'h200, 1'b0, 1'b1);
        run_sample("t5 newgain", 2'd0, 12'h200, 12'h100, 1'b0, 1'b0);

        // Reset during MUL (cnt=5): accept edge, ADD edge, then 5 MUL edges
        @(negedge clk);
        in_vld = 1'b1; in_ch = 2'd3; in_data = 12'h300;
        @(posedge clk); #1;
        in_vld = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6 busy_pre", busy, 1);
        nRST = 1'b0;
        #1;
        check("t6 rst", {out_vld, in_rdy, busy}, 3'b010);
        @(negedge clk);
        nRST = 1'b1;
        run_sample("t6 ch2_dflt", 2'd2, 12'h0AB, 12'h0AB, 1'b0, 1'b0);
        run_sample("t6 ch3_dflt", 2'd3, 12'h400, 12'h400, 1'b0, 1'b0);
        run_sample("t6 ch0_dflt", 2'd0, 12'h200, 12'h200, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
